linelength: RTL and testbench

Streaming line-length feature extractor for the signal-feature pipeline. On each enabled sample it computes the absolute difference from the previous sample and keeps a running sum of the last `win_len` differences. The output is the windowed line length, a standard seizure-detection feature. It sits downstream of the sample source and upstream of the classifier/threshold stage.

---
 rtl/linelength_pkg.sv | 5 +
 rtl/linelength_window_buf.sv | 30 +++
 rtl/linelength.sv | 61 ++++++
 tb/tb_linelength.sv | 103 ++++++++++
 4 files changed

// File: rtl/linelength_pkg.sv
// rtl/linelength_pkg.sv - default geometry shared by the line-length feature block
package linelength_pkg;
  localparam int LL_DEFAULT_DATA_WIDTH = 31;
  localparam int LL_DEFAULT_WIN_LEN    = 16;
endpackage

// File: rtl/linelength_window_buf.sv
// rtl/linelength_window_buf.sv - circular buffer of absolute differences
// Presents the oldest entry (at the write pointer) before it is overwritten.
module ll_window_buf #(
  parameter int ENTRY_W = 33,
  parameter int DEPTH   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  output logic [ENTRY_W-1:0] oldest_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wp_q;

  assign oldest_o = mem_q[wp_q];

  // DEPTH is a power of two, so the pointer wraps by natural overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q <= '0;
    end else if (we_i) begin
      mem_q[wp_q] <= wdata_i;
      wp_q        <= wp_q + 1'b1;
    end
  end
endmodule

// File: rtl/linelength.sv
// rtl/linelength.sv - windowed line length: running sum of |x[n]-x[n-1]|
// Output saturates to the largest positive signed value.
module linelength
  import linelength_pkg::*;
#(
  parameter int data_width = LL_DEFAULT_DATA_WIDTH,
  parameter int win_len    = LL_DEFAULT_WIN_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width:0]   din,
  input  logic                  en,
  output logic [data_width:0]   dout
);
  localparam int LL_LOG2_WIN = $clog2(win_len);
  localparam int AD_W        = data_width + 2;
  localparam int ACC_W       = data_width + 2 + LL_LOG2_WIN;
  localparam logic [ACC_W-1:0] SAT_LIMIT = {{(ACC_W - data_width){1'b0}}, {data_width{1'b1}}};

  logic [data_width:0] prev_q;
  logic                first_q;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [data_width:0] dout_q, dout_d;
  logic [AD_W-1:0]     diff, ad, oldest;

  ll_window_buf #(
    .ENTRY_W (AD_W),
    .DEPTH   (win_len)
  ) u_buf (
    .clk_i    (clk),
    .rst_ni   (rst),
    .we_i     (en),
    .wdata_i  (ad),
    .oldest_o (oldest)
  );

  // One extra bit of sign extension keeps the difference from overflowing
  always_comb begin
    diff   = {din[data_width], din} - {prev_q[data_width], prev_q};
    ad     = diff[AD_W-1] ? -diff : diff;
    if (first_q) ad = '0;
    acc_d  = acc_q + {{LL_LOG2_WIN{1'b0}}, ad} - {{LL_LOG2_WIN{1'b0}}, oldest};
    dout_d = (acc_d > SAT_LIMIT) ? {1'b0, {data_width{1'b1}}} : acc_d[data_width:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= '0;
      first_q <= 1'b1;
      acc_q   <= '0;
      dout_q  <= '0;
    end else if (en) begin
      prev_q  <= din;
      first_q <= 1'b0;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;
endmodule

// File: tb/tb_linelength.sv
// tb/tb_linelength.sv - directed self-checking bench for linelength
module tb_linelength;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] din = '0;
  logic        en  = 1'b0;
  logic [31:0] dout;

  int n_cmp = 0;
  int n_err = 0;

  linelength dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .en   (en),
    .dout (dout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic push(input logic [31:0] v, input logic [31:0] exp, input string tag);
    din = v;
    en  = 1'b1;
    @(posedge clk);
    #1;
    check_eq(tag, dout, exp);
  endtask

  task automatic do_reset();
    en  = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("reset_dout", dout, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [31:0] seq_s [6];
  logic [31:0] seq_e [6];
  logic [31:0] rs_s  [8];
  logic [31:0] rs_e  [8];

  initial begin
    #3;
    check_eq("por_dout", dout, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 40; i++) push(32'd1000, 32'd0, "const");

    do_reset();
    for (int i = 0; i < 24; i++)
      push((i % 2 == 0) ? 32'd1000 : 32'd300, (i < 16) ? 32'(i * 700) : 32'd11200, "alt");

    do_reset();
    seq_s = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_EEEE, 32'hFFFF_FBA9, 32'd2222};
    seq_e = '{32'd0, 32'd1, 32'd2, 32'd4370, 32'd7629, 32'd10962};
    for (int i = 0; i < 6; i++) push(seq_s[i], seq_e[i], "sign");

    do_reset();
    for (int i = 0; i < 20; i++)
      push((i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000, (i == 0) ? 32'd0 : 32'h7FFF_FFFF, "extreme");

    do_reset();
    push(32'd10, 32'd0, "gate_first");
    push(32'd20, 32'd10, "gate_second");
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = 32'd999 + 32'(i * 37);
      @(posedge clk);
      #1;
      check_eq("gate_hold", dout, 32'd10);
    end
    push(32'd25, 32'd15, "gate_resume");

    do_reset();
    rs_s = '{32'd100, 32'd150, 32'd120, 32'd200, 32'd180, 32'd180, 32'd90, 32'd100};
    rs_e = '{32'd0, 32'd50, 32'd80, 32'd160, 32'd180, 32'd180, 32'd270, 32'd280};
    for (int i = 0; i < 8; i++) push(rs_s[i], rs_e[i], "prereset");
    en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_reset", dout, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    push(32'd700, 32'd0, "post_first");
    push(32'd650, 32'd50, "post_second");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
